// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_WIDTH : operand width (two lookahead groups)
//   CLA_GROUP : bits per lookahead group
//   pg_t      : stage-1 register contents (per-bit propagate/generate + carry-in)
package cla_pkg;

  localparam int CLA_WIDTH = 8;
  localparam int CLA_GROUP = 4;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] g;
    logic                 cin;
  } pg_t;

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group.
// Ports:
//   p[3:0], g[3:0] : per-bit propagate / generate
//   ci             : carry into bit 0 of the group
//   c[3:1]         : internal carries into bits 1..3
//   P, G           : group propagate / generate for chaining
module cla4_group
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] p,
  input  logic [CLA_GROUP-1:0] g,
  input  logic                 ci,
  output logic [CLA_GROUP-1:1] c,
  output logic                 P,
  output logic                 G
);

  // Fully expanded lookahead terms: every carry is a two-level function of
  // p/g/ci, no ripple through neighbouring carries.
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla8_pipe_adder.sv
// Two-stage pipelined 8-bit carry-lookahead adder with valid/ready on both
// sides. S1 registers per-bit p/g and cin; S2 resolves carries through two
// chained 4-bit lookahead groups and registers sum, carry-out and overflow.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : a+b+cin mod 256, carry out of bit 7, signed overflow
module cla8_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = CLA_WIDTH / CLA_GROUP;

  pg_t                s1_reg;
  logic               s1_v;
  logic               s2_v;
  logic               s1_load;
  logic               s2_load;
  logic [CLA_WIDTH:0] carry;
  logic [NGRP:0]      grp_ci;

  // S1 may refill whenever it is empty or its beat is moving on to S2 in the
  // same edge; held low through reset so nothing is accepted then.
  assign in_ready  = rst_n && (!s1_v || !s2_v || out_ready);
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign out_valid = s2_v;

  // Group chaining: each group's carry-in comes from the previous group's
  // P/G, so c4 and c8 are single lookahead terms rather than a ripple.
  assign grp_ci[0] = s1_reg.cin;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic                 grp_p;
      logic                 grp_g;
      logic [CLA_GROUP-1:1] grp_c;

      cla4_group u_grp (
        .p  (s1_reg.p[gi*CLA_GROUP +: CLA_GROUP]),
        .g  (s1_reg.g[gi*CLA_GROUP +: CLA_GROUP]),
        .ci (grp_ci[gi]),
        .c  (grp_c),
        .P  (grp_p),
        .G  (grp_g)
      );

      assign grp_ci[gi+1]                          = grp_g | (grp_p & grp_ci[gi]);
      assign carry[gi*CLA_GROUP]                   = grp_ci[gi];
      assign carry[gi*CLA_GROUP+1 +: CLA_GROUP-1]  = grp_c;
    end
  endgenerate

  assign carry[CLA_WIDTH] = grp_ci[NGRP];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_reg <= {a ^ b, a & b, cin};
        s1_v   <= 1'b1;
      end else if (s2_load) begin
        s1_v   <= 1'b0;
      end

      if (s2_load) begin
        sum  <= s1_reg.p ^ carry[CLA_WIDTH-1:0];
        cout <= carry[CLA_WIDTH];
        // Signed overflow: carry into the sign bit differs from carry out.
        ovf  <= carry[CLA_WIDTH-1] ^ carry[CLA_WIDTH];
        s2_v <= 1'b1;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla8_pipe_adder.sv
// Self-checking bench for cla8_pipe_adder: reset, arithmetic corners,
// throughput, backpressure, mid-flight reset and an operand sweep with
// random output stalls checked against a scoreboard.
module tb_cla8_pipe_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int         n_checks   = 0;
  int         n_errors   = 0;
  int         n_drained  = 0;
  logic       rand_ready = 1'b0;
  logic       verbose    = 1'b1;
  logic [9:0] exp_q[$];

  cla8_pipe_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer addition.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {8'b0, ci};
    v    = (x[7] == y[7]) && (full[7] != x[7]);
    return {v, full[8], full[7:0]};
  endfunction

  // Scoreboard: sampled on the falling edge, while inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 32'(1), 32'(0));
        end else begin
          check_val("sb_result", 32'({ovf, cout, sum}), 32'(exp_q.pop_front()));
          n_drained++;
          if (verbose)
            $display("out: sum=0x%02h cout=%0b ovf=%0b t=%0t", sum, cout, ovf, $time);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin));
        if (verbose)
          $display("in : a=0x%02h b=0x%02h cin=%0b t=%0t", a, b, cin, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int   waited;
    logic acc;
    waited = 0;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    do begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_ready;
      tick();
      waited++;
    end while (!acc && waited < 50);
    if (!acc) check_val("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && w < 20) begin
      tick();
      w++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  logic [7:0] va[4];
  logic [7:0] vb[4];
  logic       vc[4];
  logic [9:0] ve[4];
  logic [7:0] btab[8];
  int         d0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    // ---- reset and idle ----
    repeat (3) begin
      tick();
      check_val("rst_in_ready", 32'(in_ready), 32'(0));
    end
    check_val("rst_out_valid", 32'(out_valid), 32'(0));
    check_val("rst_sum", 32'(sum), 'h00);
    check_val("rst_cout", 32'(cout), 32'(0));
    check_val("rst_ovf", 32'(ovf), 32'(0));
    rst_n = 1'b1;
    #1;
    check_val("idle_in_ready", 32'(in_ready), 32'(1));
    tick();
    check_val("idle_out_valid", 32'(out_valid), 32'(0));

    // ---- arithmetic corners, back-to-back; expected {ovf,cout,sum} ----
    va[0] = 8'h7F; vb[0] = 8'h01; vc[0] = 1'b0; ve[0] = 10'h280;
    va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0; ve[1] = 10'h100;
    va[2] = 8'hFF; vb[2] = 8'h00; vc[2] = 1'b1; ve[2] = 10'h100;
    va[3] = 8'h80; vb[3] = 8'h80; vc[3] = 1'b0; ve[3] = 10'h300;
    out_ready = 1'b1;
    // Beat captured into S1 at edge k reaches the S2 outputs after edge k+1.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        a = va[k]; b = vb[k]; cin = vc[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k == 0) begin
        check_val("corner_lat_early", 32'(out_valid), 32'(0));
      end else begin
        check_val("corner_valid", 32'(out_valid), 32'(1));
        check_val("corner_result", 32'({ovf, cout, sum}), 32'(ve[k-1]));
      end
    end
    tick();
    check_val("corner_idle", 32'(out_valid), 32'(0));

    // ---- throughput: 16 beats, one per cycle ----
    d0 = n_drained;
    for (int k = 0; k < 17; k++) begin
      if (k < 16) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        #1;
        check_val("tput_in_ready", 32'(in_ready), 32'(1));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= 1) check_val("tput_valid", 32'(out_valid), 32'(1));
    end
    drain();
    check_val("tput_count", 32'(n_drained - d0), 32'(16));

    // ---- backpressure ----
    d0 = n_drained;
    out_ready = 1'b0;
    a = 8'h10; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    #1;
    check_val("bp_ready0", 32'(in_ready), 32'(1));
    tick();
    a = 8'h20; b = 8'h02;
    #1;
    check_val("bp_ready1", 32'(in_ready), 32'(1));
    tick();
    a = 8'h30; b = 8'h03;
    #1;
    check_val("bp_ready_drop", 32'(in_ready), 32'(0));
    repeat (4) begin
      tick();
      check_val("bp_hold_valid", 32'(out_valid), 32'(1));
      check_val("bp_hold_sum", 32'(sum), 'h11);
      check_val("bp_ready_low", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_ready_release", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check_val("bp_second", 32'(sum), 'h22);
    tick();
    check_val("bp_third", 32'(sum), 'h33);
    drain();
    check_val("bp_count", 32'(n_drained - d0), 32'(3));

    // ---- reset with two beats in flight ----
    out_ready = 1'b0;
    a = 8'h05; b = 8'h06; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h07; b = 8'h08;
    tick();
    in_valid = 1'b0;
    check_val("midrst_pre_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    tick();
    check_val("midrst_valid", 32'(out_valid), 32'(0));
    check_val("midrst_sum", 32'(sum), 'h00);
    check_val("midrst_in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      check_val("midrst_stale", 32'(out_valid), 32'(0));
    end

    // ---- operand sweep with random output stalls ----
    verbose    = 1'b0;
    rand_ready = 1'b1;
    d0 = n_drained;
    btab[0] = 8'h00; btab[1] = 8'h01; btab[2] = 8'h7F; btab[3] = 8'h80;
    btab[4] = 8'hFF; btab[5] = 8'h55; btab[6] = 8'hAA;
    for (int ai = 0; ai < 256; ai++) begin
      btab[7] = 8'($urandom_range(0, 255));
      for (int j = 0; j < 8; j++) begin
        for (int c = 0; c < 2; c++) begin
          send(8'(ai), btab[j], 1'(c));
        end
      end
    end
    rand_ready = 1'b0;
    drain();
    check_val("sweep_count", 32'(n_drained - d0), 32'(4096));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
